// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline stages.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // ALU operation codes as decoded into alu_control
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  // Conditional branch kind
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_LT   = 2'b11
  } branch_t;

  // Writeback result source
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // Operand forwarding select; the reserved code behaves like FWD_RF
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for the execute stage.
module alu
  import pipe_pkg::*;
#(
  parameter int W = pipe_pkg::XLEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_t      op,
  output logic [W-1:0] result
);

  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;
  logic           lt;

  // Only the low log2(W) bits of b form the shift amount
  assign shamt = b[SHW-1:0];
  assign lt    = $signed(a) < $signed(b);

  // Select the operation; arithmetic wraps naturally at W bits
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(W-1){1'b0}}, lt};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, branch resolution, EX/MEM register.
module execute_stage
  import pipe_pkg::*;
#(
  parameter int XLEN       = pipe_pkg::XLEN,
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_m,
  input  logic                  flush_m,
  input  logic                  reg_write_e,
  input  logic [1:0]            result_src_e,
  input  logic                  mem_write_e,
  input  logic                  jump_e,
  input  logic [1:0]            branch_e,
  input  logic [2:0]            alu_control_e,
  input  logic                  alu_src_e,
  input  logic [XLEN-1:0]       rd1_e,
  input  logic [XLEN-1:0]       rd2_e,
  input  logic [XLEN-1:0]       pc_e,
  input  logic [XLEN-1:0]       imm_ext_e,
  input  logic [XLEN-1:0]       pc_plus4_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [1:0]            forward_a_e,
  input  logic [1:0]            forward_b_e,
  input  logic [XLEN-1:0]       result_w,
  output logic                  pc_src_e,
  output logic [XLEN-1:0]       pc_target_e,
  output logic                  reg_write_m,
  output logic                  mem_write_m,
  output logic [1:0]            result_src_m,
  output logic [XLEN-1:0]       alu_result_m,
  output logic [XLEN-1:0]       write_data_m,
  output logic [XLEN-1:0]       pc_plus4_m,
  output logic [REG_ADDR_W-1:0] rd_m
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            eq;
  logic            lt;
  logic            taken;

  // A-operand forwarding; the MEM leg feeds back this block's own register
  always_comb begin
    src_a = rd1_e;
    case (fwd_sel_t'(forward_a_e))
      FWD_W:   src_a = result_w;
      FWD_M:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
  end

  // B-operand forwarding; this value is also the store data
  always_comb begin
    fwd_b = rd2_e;
    case (fwd_sel_t'(forward_b_e))
      FWD_W:   fwd_b = result_w;
      FWD_M:   fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_ext_e : fwd_b;

  alu #(.W(XLEN)) u_alu (
    .a      (src_a),
    .b      (src_b),
    .op     (alu_op_t'(alu_control_e)),
    .result (alu_result)
  );

  // Branch compare always uses the register operands, never the immediate
  assign eq = (src_a == fwd_b);
  assign lt = $signed(src_a) < $signed(fwd_b);

  // Resolve the branch condition from the decoded branch kind
  always_comb begin
    taken = 1'b0;
    case (branch_t'(branch_e))
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt;
      default: taken = 1'b0;
    endcase
  end

  // Redirect is combinational so fetch can react in the same cycle
  assign pc_src_e    = jump_e | taken;
  assign pc_target_e = pc_e + imm_ext_e;

  // EX/MEM register: reset and flush both insert a bubble, flush beats stall
  always_ff @(posedge clk) begin
    if (rst || flush_m) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else if (!stall_m) begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      alu_result_m <= alu_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;
  import pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_m, flush_m;
  logic        reg_write_e, mem_write_e, jump_e, alu_src_e;
  logic [1:0]  result_src_e, branch_e, forward_a_e, forward_b_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e, result_w;
  logic [4:0]  rd_e;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;

  int n_cmp = 0;
  int n_err = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall_m(stall_m), .flush_m(flush_m),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
    .pc_plus4_e(pc_plus4_e), .rd_e(rd_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .result_w(result_w),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_m = 0; flush_m = 0;
    reg_write_e = 0; result_src_e = 0; mem_write_e = 0; jump_e = 0;
    branch_e = BR_NONE; alu_control_e = ALU_ADD; alu_src_e = 0;
    rd1_e = 0; rd2_e = 0; pc_e = 0; imm_ext_e = 0; pc_plus4_e = 0; rd_e = 0;
    forward_a_e = FWD_RF; forward_b_e = FWD_RF; result_w = 0;
  endtask

  initial begin
    idle();
    // Reset with nonzero inputs
    rst = 1;
    reg_write_e = 1; mem_write_e = 1; result_src_e = RES_PC4;
    rd1_e = 32'h11; rd2_e = 32'h22; pc_e = 32'h200; imm_ext_e = 32'h40;
    pc_plus4_e = 32'h204; rd_e = 5'd7;
    tick();
    chk("rst_reg_write_m", {31'b0, reg_write_m}, 32'h0);
    chk("rst_mem_write_m", {31'b0, mem_write_m}, 32'h0);
    chk("rst_result_src_m", {30'b0, result_src_m}, 32'h0);
    chk("rst_alu_result_m", alu_result_m, 32'h0);
    chk("rst_write_data_m", write_data_m, 32'h0);
    chk("rst_pc_plus4_m", pc_plus4_m, 32'h0);
    chk("rst_rd_m", {27'b0, rd_m}, 32'h0);
    chk("rst_pc_target_e", pc_target_e, 32'h240);
    rst = 0;

    // ALU sweep on register operands
    idle();
    rd1_e = 32'hFFFF_FFF0; rd2_e = 32'h10;
    alu_control_e = ALU_ADD; tick(); chk("alu_add", alu_result_m, 32'h0);
    alu_control_e = ALU_SUB; tick(); chk("alu_sub", alu_result_m, 32'hFFFF_FFE0);
    alu_control_e = ALU_SLT; tick(); chk("alu_slt", alu_result_m, 32'h1);
    alu_control_e = ALU_SRL; tick(); chk("alu_srl", alu_result_m, 32'h0000_FFFF);
    alu_control_e = ALU_AND; tick(); chk("alu_and", alu_result_m, 32'h10);
    alu_control_e = ALU_OR;  tick(); chk("alu_or",  alu_result_m, 32'hFFFF_FFF0);
    alu_control_e = ALU_XOR; tick(); chk("alu_xor", alu_result_m, 32'hFFFF_FFE0);
    // slt reversed: 16 < -16 is false
    rd1_e = 32'h10; rd2_e = 32'hFFFF_FFF0;
    alu_control_e = ALU_SLT; tick(); chk("alu_slt_neg", alu_result_m, 32'h0);

    // Immediate operand: shift amount is imm[4:0] = 5
    idle();
    rd1_e = 32'h3; rd2_e = 32'h10; imm_ext_e = 32'h25; alu_src_e = 1;
    alu_control_e = ALU_SLL; tick();
    chk("alu_sll_imm", alu_result_m, 32'h60);
    chk("wd_ignores_alu_src", write_data_m, 32'h10);

    // Forwarding: x5 = 4 + 3, then the next op takes x5 from MEM
    idle();
    rd1_e = 32'h4; imm_ext_e = 32'h3; alu_src_e = 1; rd_e = 5'd5; reg_write_e = 1;
    tick();
    chk("fwd_prod", alu_result_m, 32'h7);
    chk("fwd_prod_rd", {27'b0, rd_m}, 32'd5);
    rd1_e = 32'h0; forward_a_e = FWD_M; tick();
    chk("fwd_a_mem", alu_result_m, 32'hA);
    forward_a_e = FWD_RF; forward_b_e = FWD_W; result_w = 32'h55; rd2_e = 32'h99;
    tick();
    chk("fwd_b_wb", write_data_m, 32'h55);
    forward_b_e = FWD_RF;
    rd1_e = 32'h9; imm_ext_e = 32'h1; forward_a_e = FWD_RSV; result_w = 32'h1000;
    tick();
    chk("fwd_a_rsv", alu_result_m, 32'hA);
    forward_a_e = FWD_W; tick();
    chk("fwd_a_wb", alu_result_m, 32'h1001);

    // Branches (combinational), imm differs from operands on purpose
    idle();
    pc_e = 32'h100; imm_ext_e = 32'h20; alu_src_e = 1;
    rd1_e = 32'h5; rd2_e = 32'h5; branch_e = BR_EQ; #1;
    chk("beq_taken", {31'b0, pc_src_e}, 32'h1);
    chk("beq_target", pc_target_e, 32'h120);
    rd1_e = 32'h20; rd2_e = 32'h5; #1;
    chk("beq_not_imm", {31'b0, pc_src_e}, 32'h0);
    rd1_e = 32'hFFFF_FFFF; rd2_e = 32'h1; branch_e = BR_LT; #1;
    chk("blt_taken", {31'b0, pc_src_e}, 32'h1);
    rd1_e = 32'h1; rd2_e = 32'hFFFF_FFFF; #1;
    chk("blt_signed_nt", {31'b0, pc_src_e}, 32'h0);
    rd1_e = 32'h7; rd2_e = 32'h7; branch_e = BR_NE; #1;
    chk("bne_eq_nt", {31'b0, pc_src_e}, 32'h0);
    rd2_e = 32'h8; #1;
    chk("bne_taken", {31'b0, pc_src_e}, 32'h1);
    rd2_e = 32'h7; branch_e = BR_NONE; #1;
    chk("no_branch", {31'b0, pc_src_e}, 32'h0);
    jump_e = 1; #1;
    chk("jump", {31'b0, pc_src_e}, 32'h1);

    // Stall / flush
    idle();
    reg_write_e = 1; result_src_e = RES_MEM; rd1_e = 32'h100; imm_ext_e = 32'h4;
    alu_src_e = 1; rd_e = 5'd9; pc_plus4_e = 32'h44; rd2_e = 32'h77;
    tick();
    chk("ld_alu", alu_result_m, 32'h104);
    chk("ld_src", {30'b0, result_src_m}, 32'h1);
    rd1_e = 32'h500; rd_e = 5'd3; pc_plus4_e = 32'h88; reg_write_e = 0; stall_m = 1;
    tick();
    chk("stall1_alu", alu_result_m, 32'h104);
    chk("stall1_rd", {27'b0, rd_m}, 32'd9);
    tick();
    chk("stall2_alu", alu_result_m, 32'h104);
    chk("stall2_pc4", pc_plus4_m, 32'h44);
    chk("stall2_rw", {31'b0, reg_write_m}, 32'h1);
    stall_m = 0; reg_write_e = 1; mem_write_e = 1;
    tick();
    chk("unstall_alu", alu_result_m, 32'h504);
    chk("unstall_rd", {27'b0, rd_m}, 32'd3);
    flush_m = 1; tick();
    chk("flush_rw", {31'b0, reg_write_m}, 32'h0);
    chk("flush_mw", {31'b0, mem_write_m}, 32'h0);
    chk("flush_rd", {27'b0, rd_m}, 32'h0);
    flush_m = 0; tick();
    chk("reload_rd", {27'b0, rd_m}, 32'd3);
    stall_m = 1; flush_m = 1; tick();
    chk("stflush_rw", {31'b0, reg_write_m}, 32'h0);
    chk("stflush_mw", {31'b0, mem_write_m}, 32'h0);
    chk("stflush_alu", alu_result_m, 32'h0);

    // Store path
    idle();
    mem_write_e = 1; alu_src_e = 1; rd2_e = 32'hDEAD_BEEF; imm_ext_e = 32'h8;
    rd1_e = 32'h1000; tick();
    chk("st_addr", alu_result_m, 32'h1008);
    chk("st_data", write_data_m, 32'hDEAD_BEEF);
    chk("st_mw", {31'b0, mem_write_m}, 32'h1);

    // Reset mid-stream discards the in-flight op
    rst = 1; tick();
    chk("rst2_mw", {31'b0, mem_write_m}, 32'h0);
    chk("rst2_alu", alu_result_m, 32'h0);
    rst = 0; tick();
    chk("post_rst_alu", alu_result_m, 32'h1008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
